// File: rtl/mccoy_instr_feeder_if.sv
// Program load port of the McCoy instruction feeder: one 6-bit instruction per beat,
// valid/ready handshake, with a last-beat marker.
interface mccoy_instr_feeder_if;
    logic       load_valid;
    logic [5:0] load_data;
    logic       load_last;
    logic       load_ready;

    modport master (
        output load_valid,
        output load_data,
        output load_last,
        input  load_ready
    );

    modport slave (
        input  load_valid,
        input  load_data,
        input  load_last,
        output load_ready
    );
endinterface

// File: rtl/mccoy_instr_feeder.sv
// Buffers a short program, then drives the McCoy core: a reset pulse of RESET_CYCLES clocks,
// followed by one instruction per clock, optionally looping.
module mccoy_instr_feeder #(
    parameter int         DEPTH        = 16,
    parameter int         RESET_CYCLES = 2,
    parameter logic [5:0] IDLE_WORD    = 6'b000000
) (
    input  logic                   clk,
    input  logic                   reset_n,
    mccoy_instr_feeder_if.slave    load,
    input  logic                   start,
    input  logic                   stop,
    input  logic                   loop_en,
    output logic [5:0]             instr,
    output logic                   core_reset,
    output logic                   running,
    output logic                   done,
    output logic [$clog2(DEPTH):0] prog_len
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int CW = $clog2(RESET_CYCLES) + 1;

    typedef enum logic [1:0] {S_IDLE, S_RST, S_RUN, S_DONE} state_t;

    state_t          state_reg, state_next;
    logic [AW-1:0]   wr_ptr_reg;
    logic [AW-1:0]   pc_reg;
    logic [PW-1:0]   prog_len_reg;
    logic [CW-1:0]   rst_cnt_reg;
    logic            last_reg;
    logic [5:0]      instr_reg;
    logic [5:0]      mem [DEPTH];

    logic ready_c;
    logic beat_acc;
    logic beat_term;
    logic start_ok;
    logic rst_over;
    logic pc_at_end;
    logic issue;

    assign beat_acc  = load.load_valid && ready_c;
    assign beat_term = load.load_last || (wr_ptr_reg == AW'(DEPTH - 1));
    assign start_ok  = start && ready_c && (prog_len_reg != '0) && (wr_ptr_reg == '0) && !beat_acc;
    assign rst_over  = (rst_cnt_reg == CW'(RESET_CYCLES - 1));
    assign pc_at_end = (PW'(pc_reg) == prog_len_reg - PW'(1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: if (start_ok) state_next = S_RST;
            S_RST: begin
                if (stop)          state_next = S_IDLE;
                else if (rst_over) state_next = S_RUN;
            end
            S_RUN: begin
                if (stop)          state_next = S_IDLE;
                else if (last_reg) state_next = S_DONE;
            end
            S_DONE: begin
                if (beat_acc)      state_next = S_IDLE;
                else if (start_ok) state_next = S_RST;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Status outputs decode the state register only, so they carry no input-to-output path.
    always_comb begin
        ready_c    = 1'b0;
        running    = 1'b0;
        done       = 1'b0;
        core_reset = 1'b0;
        issue      = 1'b0;
        case (state_reg)
            S_IDLE: begin
                ready_c    = 1'b1;
                core_reset = 1'b1;
            end
            S_RST: begin
                running    = 1'b1;
                core_reset = 1'b1;
                issue      = !stop && rst_over;
            end
            S_RUN: begin
                running    = 1'b1;
                issue      = !stop && !last_reg;
            end
            S_DONE: begin
                ready_c    = 1'b1;
                done       = 1'b1;
            end
            default: core_reset = 1'b1;
        endcase
    end

    assign load.load_ready = ready_c;
    assign instr           = instr_reg;
    assign prog_len        = prog_len_reg;

    always_ff @(posedge clk) begin
        if (beat_acc) begin
            mem[wr_ptr_reg] <= load.load_data;
        end
    end

    // last_reg marks that the word now on instr ends a non-looping program; DONE follows next edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_reg   <= '0;
            pc_reg       <= '0;
            prog_len_reg <= '0;
            rst_cnt_reg  <= '0;
            last_reg     <= 1'b0;
            instr_reg    <= IDLE_WORD;
        end else begin
            if (beat_acc) begin
                if (beat_term) begin
                    wr_ptr_reg   <= '0;
                    prog_len_reg <= PW'(wr_ptr_reg) + PW'(1);
                end else begin
                    wr_ptr_reg   <= wr_ptr_reg + AW'(1);
                end
            end

            if (state_reg == S_RST) rst_cnt_reg <= rst_cnt_reg + CW'(1);
            else                    rst_cnt_reg <= '0;

            if (issue) begin
                instr_reg <= mem[pc_reg];
                last_reg  <= pc_at_end && !loop_en;
                pc_reg    <= pc_at_end ? '0 : pc_reg + AW'(1);
            end else begin
                instr_reg <= IDLE_WORD;
                last_reg  <= 1'b0;
                pc_reg    <= '0;
            end
        end
    end
endmodule

// File: tb/tb_mccoy_instr_feeder.sv
// Directed checks of the McCoy instruction feeder: load, reset pulse, run, loop, stop,
// overflow, load/start hazards and asynchronous reset.
module tb_mccoy_instr_feeder;
    logic       clk = 1'b0;
    logic       reset_n;
    logic       start;
    logic       stop;
    logic       loop_en;
    logic [5:0] instr;
    logic       core_reset;
    logic       running;
    logic       done;
    logic [4:0] prog_len;

    int vec_cnt  = 0;
    int miss_cnt = 0;

    always #5 clk = ~clk;

    mccoy_instr_feeder_if lif ();

    mccoy_instr_feeder dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .load       (lif),
        .start      (start),
        .stop       (stop),
        .loop_en    (loop_en),
        .instr      (instr),
        .core_reset (core_reset),
        .running    (running),
        .done       (done),
        .prog_len   (prog_len)
    );

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_beat(input logic [5:0] d, input logic l);
        lif.load_valid = 1'b1;
        lif.load_data  = d;
        lif.load_last  = l;
        $display("load beat data=0x%02h last=%0d ready=%0d", d, l, lif.load_ready);
        tick();
        lif.load_valid = 1'b0;
        lif.load_last  = 1'b0;
    endtask

    // Start pulse, then walk through the two reset cycles; returns with mem[0] on instr.
    task automatic start_run(input logic lp);
        loop_en = lp;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        check_vec("start_running", {31'd0, running}, 32'd1);
        check_vec("start_core_reset", {31'd0, core_reset}, 32'd1);
        check_vec("start_instr_idle", {26'd0, instr}, 32'h0);
        tick();
        check_vec("rst2_core_reset", {31'd0, core_reset}, 32'd1);
        tick();
        check_vec("run_core_reset", {31'd0, core_reset}, 32'd0);
    endtask

    initial begin
        logic [5:0] prog3 [3];
        prog3[0] = 6'h05;
        prog3[1] = 6'h2A;
        prog3[2] = 6'h3F;

        reset_n = 1'b0;
        start = 1'b0;
        stop = 1'b0;
        loop_en = 1'b0;
        lif.load_valid = 1'b0;
        lif.load_data = 6'h00;
        lif.load_last = 1'b0;
        repeat (3) tick();
        check_vec("rst_core_reset", {31'd0, core_reset}, 32'd1);
        reset_n = 1'b1;
        tick();
        check_vec("idle_core_reset", {31'd0, core_reset}, 32'd1);
        check_vec("idle_instr", {26'd0, instr}, 32'h0);
        check_vec("idle_load_ready", {31'd0, lif.load_ready}, 32'd1);
        check_vec("idle_prog_len", {27'd0, prog_len}, 32'd0);
        check_vec("idle_done", {31'd0, done}, 32'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check_vec("empty_start_ignored", {31'd0, running}, 32'd0);

        // Three-word program, single pass
        load_beat(6'h05, 1'b0);
        load_beat(6'h2A, 1'b0);
        check_vec("partial_prog_len", {27'd0, prog_len}, 32'd0);
        load_beat(6'h3F, 1'b1);
        check_vec("prog_len_3", {27'd0, prog_len}, 32'd3);
        start_run(1'b0);
        for (int k = 0; k < 3; k++) begin
            check_vec($sformatf("once_word%0d", k), {26'd0, instr}, {26'd0, prog3[k]});
            check_vec("once_running", {31'd0, running}, 32'd1);
            tick();
        end
        check_vec("once_done_instr", {26'd0, instr}, 32'h0);
        check_vec("once_done", {31'd0, done}, 32'd1);
        check_vec("once_done_running", {31'd0, running}, 32'd0);
        check_vec("once_done_core_reset", {31'd0, core_reset}, 32'd0);
        check_vec("once_prog_len", {27'd0, prog_len}, 32'd3);

        // Looping run from DONE, load attempt during RUN, then stop
        start_run(1'b1);
        for (int k = 0; k < 8; k++) begin
            check_vec($sformatf("loop_word%0d", k), {26'd0, instr}, {26'd0, prog3[k % 3]});
            if (k == 4) begin
                lif.load_valid = 1'b1;
                lif.load_data  = 6'h11;
                lif.load_last  = 1'b1;
                check_vec("run_load_ready", {31'd0, lif.load_ready}, 32'd0);
            end
            tick();
        end
        lif.load_valid = 1'b0;
        lif.load_last  = 1'b0;
        stop = 1'b1;
        start = 1'b1;
        tick();
        stop = 1'b0;
        start = 1'b0;
        check_vec("stop_core_reset", {31'd0, core_reset}, 32'd1);
        check_vec("stop_instr", {26'd0, instr}, 32'h0);
        check_vec("stop_running", {31'd0, running}, 32'd0);
        check_vec("stop_done", {31'd0, done}, 32'd0);

        // Buffer untouched by the beat offered during RUN
        start_run(1'b0);
        for (int k = 0; k < 3; k++) begin
            check_vec($sformatf("again_word%0d", k), {26'd0, instr}, {26'd0, prog3[k]});
            tick();
        end
        check_vec("again_done", {31'd0, done}, 32'd1);

        // Start concurrent with an accepted beat: beat written, no run
        lif.load_valid = 1'b1;
        lif.load_data  = 6'h15;
        lif.load_last  = 1'b1;
        start = 1'b1;
        tick();
        lif.load_valid = 1'b0;
        lif.load_last  = 1'b0;
        start = 1'b0;
        check_vec("concur_running", {31'd0, running}, 32'd0);
        check_vec("concur_prog_len", {27'd0, prog_len}, 32'd1);
        check_vec("concur_done_cleared", {31'd0, done}, 32'd0);
        start_run(1'b0);
        check_vec("len1_word", {26'd0, instr}, 32'h15);
        tick();
        check_vec("len1_done", {31'd0, done}, 32'd1);
        check_vec("len1_instr_idle", {26'd0, instr}, 32'h0);

        // Partial load in DONE, then start must be ignored
        load_beat(6'h07, 1'b0);
        check_vec("beat_in_done_clears", {31'd0, done}, 32'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check_vec("partial_start_ignored", {31'd0, running}, 32'd0);
        load_beat(6'h08, 1'b1);
        check_vec("prog_len_2", {27'd0, prog_len}, 32'd2);

        // Overflow: sixteen beats without load_last
        for (int k = 0; k < 16; k++) begin
            if (k == 15) check_vec("pre_wrap_prog_len", {27'd0, prog_len}, 32'd2);
            load_beat(6'h20 + 6'(k), 1'b0);
        end
        check_vec("full_prog_len", {27'd0, prog_len}, 32'd16);
        start_run(1'b0);
        for (int k = 0; k < 16; k++) begin
            check_vec($sformatf("full_word%0d", k), {26'd0, instr}, 32'h20 + k);
            tick();
        end
        check_vec("full_done", {31'd0, done}, 32'd1);
        check_vec("full_done_instr", {26'd0, instr}, 32'h0);

        // Asynchronous reset between edges during RUN
        start_run(1'b1);
        tick();
        tick();
        check_vec("pre_areset_word", {26'd0, instr}, 32'h22);
        #2;
        reset_n = 1'b0;
        #1;
        check_vec("areset_core_reset", {31'd0, core_reset}, 32'd1);
        check_vec("areset_instr", {26'd0, instr}, 32'h0);
        check_vec("areset_running", {31'd0, running}, 32'd0);
        check_vec("areset_load_ready", {31'd0, lif.load_ready}, 32'd1);
        check_vec("areset_prog_len", {27'd0, prog_len}, 32'd0);
        tick();
        reset_n = 1'b1;
        tick();
        check_vec("post_areset_running", {31'd0, running}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
